// File: rtl/data_bus_port_if.sv
// Module-side signal bundle for the OR data bus access port.
// slave = the port itself, master = the module logic driving it.
interface data_bus_port_if #(
  parameter int DATA_WIDTH = 8,
  parameter int TX_DEPTH   = 4
);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [CW-1:0]         tx_count;
  logic                  bus_req;
  logic                  bus_grant;
  logic [DATA_WIDTH-1:0] bus_drive;
  logic [DATA_WIDTH-1:0] bus_data_in;
  logic                  bus_sel;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_overrun;
  logic                  overrun_clr;

  modport slave (
    input  tx_valid, tx_data, bus_grant, bus_data_in, bus_sel, rx_ready, overrun_clr,
    output tx_ready, tx_count, bus_req, bus_drive, rx_valid, rx_data, rx_overrun
  );

  modport master (
    output tx_valid, tx_data, bus_grant, bus_data_in, bus_sel, rx_ready, overrun_clr,
    input  tx_ready, tx_count, bus_req, bus_drive, rx_valid, rx_data, rx_overrun
  );
endinterface

// File: rtl/data_bus_port.sv
// OR-bus access port: TX FIFO + request/grant/drive FSM, and a single-entry
// RX holding register with sticky overrun.
module data_bus_port #(
  parameter int DATA_WIDTH = 8,
  parameter int TX_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  data_bus_port_if.slave   port
);
  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(TX_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRIVE} state_t;

  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_mem [TX_DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_drive;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid, r_rx_overrun;
  logic                  w_push, w_pop, w_cap, w_ovr;

  assign w_push = port.tx_valid && port.tx_ready;
  assign w_pop  = (r_state == REQ) && port.bus_grant && (r_count != '0);
  assign w_cap  = port.bus_sel && (!r_rx_valid || port.rx_ready);
  assign w_ovr  = port.bus_sel && r_rx_valid && !port.rx_ready;

  // Power-of-two depth: pointers wrap naturally at AW bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= port.tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (r_count != '0) w_next = REQ;
      REQ:     if (w_pop) w_next = DRIVE;
      DRIVE:   w_next = (r_count != '0) ? REQ : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Registered drive: non-zero only in the cycle after a grant, so the OR bus stays clean.
  always_ff @(posedge clk) begin
    if (rst) r_drive <= '0;
    else     r_drive <= w_pop ? r_mem[r_rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_valid   <= 1'b0;
      r_rx_data    <= '0;
      r_rx_overrun <= 1'b0;
    end else begin
      if (w_cap) begin
        r_rx_valid <= 1'b1;
        r_rx_data  <= port.bus_data_in;
      end else if (port.rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      if (w_ovr)                 r_rx_overrun <= 1'b1;
      else if (port.overrun_clr) r_rx_overrun <= 1'b0;
    end
  end

  assign port.tx_ready   = (r_count != FULL);
  assign port.tx_count   = r_count;
  assign port.bus_req    = (r_state == REQ);
  assign port.bus_drive  = r_drive;
  assign port.rx_valid   = r_rx_valid;
  assign port.rx_data    = r_rx_data;
  assign port.rx_overrun = r_rx_overrun;
endmodule

// File: tb/tb_data_bus_port.sv
// Directed vector bench for data_bus_port: a cycle table plus hand-written
// FIFO wrap, full push/pop and reset-mid-drive sequences.
module tb_data_bus_port;
  localparam int DW = 8;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_bus_port_if #(.DATA_WIDTH(DW), .TX_DEPTH(D)) bif ();

  data_bus_port #(.DATA_WIDTH(DW), .TX_DEPTH(D)) dut (
    .clk  (clk),
    .rst  (rst),
    .port (bif.slave)
  );

  typedef struct packed {
    logic          rst;
    logic          tv;
    logic [DW-1:0] td;
    logic          gnt;
    logic          sel;
    logic [DW-1:0] din;
    logic          rdy;
    logic          clr;
  } in_t;

  typedef struct packed {
    logic          trdy;
    logic [2:0]    cnt;
    logic          req;
    logic [DW-1:0] drv;
    logic          rv;
    logic [DW-1:0] rd;
    logic          ovr;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  localparam int NT = 21;
  vec_t tbl [NT];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic in_t I(input bit r, input bit tv, input logic [DW-1:0] td,
                            input bit g, input bit s, input logic [DW-1:0] din,
                            input bit rdy, input bit clr);
    in_t v;
    v.rst = r; v.tv = tv; v.td = td; v.gnt = g;
    v.sel = s; v.din = din; v.rdy = rdy; v.clr = clr;
    return v;
  endfunction

  function automatic out_t O(input bit trdy, input logic [2:0] cnt, input bit req,
                             input logic [DW-1:0] drv, input bit rv,
                             input logic [DW-1:0] rd, input bit ovr);
    out_t v;
    v.trdy = trdy; v.cnt = cnt; v.req = req; v.drv = drv;
    v.rv = rv; v.rd = rd; v.ovr = ovr;
    return v;
  endfunction

  // TX-only expectation with the RX side idle and cleared.
  function automatic out_t T(input bit trdy, input logic [2:0] cnt, input bit req,
                             input logic [DW-1:0] drv);
    return O(trdy, cnt, req, drv, 1'b0, 8'h00, 1'b0);
  endfunction

  task automatic step(input in_t v);
    rst             = v.rst;
    bif.tx_valid    = v.tv;
    bif.tx_data     = v.td;
    bif.bus_grant   = v.gnt;
    bif.bus_sel     = v.sel;
    bif.bus_data_in = v.din;
    bif.rx_ready    = v.rdy;
    bif.overrun_clr = v.clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input out_t e);
    out_t a;
    a.trdy = bif.tx_ready;  a.cnt = bif.tx_count; a.req = bif.bus_req;
    a.drv  = bif.bus_drive; a.rv  = bif.rx_valid; a.rd  = bif.rx_data;
    a.ovr  = bif.rx_overrun;
    n_vec++;
    if (a !== e) begin
      n_miss++;
      $display("FAIL %s: got trdy=%b cnt=%0d req=%b drv=%h rv=%b rd=%h ovr=%b, expected trdy=%b cnt=%0d req=%b drv=%h rv=%b rd=%h ovr=%b",
               name, a.trdy, a.cnt, a.req, a.drv, a.rv, a.rd, a.ovr,
               e.trdy, e.cnt, e.req, e.drv, e.rv, e.rd, e.ovr);
    end
  endtask

  task automatic stepchk(input string name, input in_t v, input out_t e);
    step(v);
    check(name, e);
  endtask

  localparam in_t NOP = '0;

  initial begin
    rst = 1'b0;
    bif.tx_valid = 1'b0; bif.tx_data = '0; bif.bus_grant = 1'b0; bif.bus_sel = 1'b0;
    bif.bus_data_in = '0; bif.rx_ready = 1'b0; bif.overrun_clr = 1'b0;

    // Expected values are the outputs visible just after each edge.
    tbl[0]  = '{I(1,0,8'h00,0,0,8'h00,0,0), O(1,0,0,8'h00,0,8'h00,0)};  // reset
    tbl[1]  = '{I(0,0,8'h00,0,0,8'h00,0,0), O(1,0,0,8'h00,0,8'h00,0)};
    tbl[2]  = '{I(0,1,8'hA5,0,0,8'h00,0,0), O(1,1,0,8'h00,0,8'h00,0)};  // push A5
    tbl[3]  = '{I(0,0,8'h00,0,0,8'h00,0,0), O(1,1,1,8'h00,0,8'h00,0)};  // REQ
    tbl[4]  = '{I(0,0,8'h00,0,0,8'h00,0,0), O(1,1,1,8'h00,0,8'h00,0)};
    tbl[5]  = '{I(0,0,8'h00,1,0,8'h00,0,0), O(1,0,0,8'hA5,0,8'h00,0)};  // grant -> drive
    tbl[6]  = '{I(0,0,8'h00,0,0,8'h00,0,0), O(1,0,0,8'h00,0,8'h00,0)};
    tbl[7]  = '{I(0,0,8'h00,0,0,8'h00,0,0), O(1,0,0,8'h00,0,8'h00,0)};
    tbl[8]  = '{I(0,0,8'h00,0,1,8'h3C,0,0), O(1,0,0,8'h00,1,8'h3C,0)};  // capture 3C
    tbl[9]  = '{I(0,0,8'h00,0,1,8'h7E,0,0), O(1,0,0,8'h00,1,8'h3C,1)};  // overrun
    tbl[10] = '{I(0,0,8'h00,0,1,8'h55,1,0), O(1,0,0,8'h00,1,8'h55,1)};  // consume+capture
    tbl[11] = '{I(0,0,8'h00,0,0,8'h00,0,1), O(1,0,0,8'h00,1,8'h55,0)};  // clear
    tbl[12] = '{I(0,0,8'h00,0,0,8'h00,1,0), O(1,0,0,8'h00,0,8'h55,0)};  // consume
    tbl[13] = '{I(0,0,8'h00,0,1,8'h99,0,1), O(1,0,0,8'h00,1,8'h99,0)};
    tbl[14] = '{I(0,0,8'h00,0,1,8'h11,0,1), O(1,0,0,8'h00,1,8'h99,1)};  // set beats clear
    tbl[15] = '{I(0,0,8'h00,0,0,8'h00,0,1), O(1,0,0,8'h00,1,8'h99,0)};
    tbl[16] = '{I(0,1,8'h22,0,1,8'h33,1,0), O(1,1,0,8'h00,1,8'h33,0)};  // TX+RX same cycle
    tbl[17] = '{I(0,0,8'h00,0,0,8'h00,1,0), O(1,1,1,8'h00,0,8'h33,0)};
    tbl[18] = '{I(0,0,8'h00,1,0,8'h00,0,0), O(1,0,0,8'h22,0,8'h33,0)};
    tbl[19] = '{I(0,0,8'h00,1,0,8'h00,0,0), O(1,0,0,8'h00,0,8'h33,0)};  // grant in DRIVE
    tbl[20] = '{I(0,0,8'h00,1,0,8'h00,0,0), O(1,0,0,8'h00,0,8'h33,0)};  // grant in IDLE

    for (int k = 0; k < NT; k++)
      stepchk($sformatf("tbl[%0d]", k), tbl[k].i, tbl[k].o);

    // Reset then idle for 10 cycles
    stepchk("idle_rst", I(1,0,8'h00,0,0,8'h00,0,0), T(1,0,0,8'h00));
    for (int k = 0; k < 10; k++)
      stepchk($sformatf("idle[%0d]", k), NOP, T(1,0,0,8'h00));

    // FIFO fill to full, overflow push ignored
    stepchk("fill1", I(0,1,8'h01,0,0,8'h00,0,0), T(1,1,0,8'h00));
    stepchk("fill2", I(0,1,8'h02,0,0,8'h00,0,0), T(1,2,1,8'h00));
    stepchk("fill3", I(0,1,8'h03,0,0,8'h00,0,0), T(1,3,1,8'h00));
    stepchk("fill4", I(0,1,8'h04,0,0,8'h00,0,0), T(0,4,1,8'h00));
    stepchk("ovfl",  I(0,1,8'h05,0,0,8'h00,0,0), T(0,4,1,8'h00));
    // Grant held high: only grants seen in REQ pop; DRIVE/IDLE grants ignored
    for (int k = 0; k < 4; k++) begin
      logic [DW-1:0] w;
      logic [2:0]    c;
      w = DW'(k + 1);
      c = 3'(3 - k);
      stepchk($sformatf("drain_drv[%0d]", k), I(0,0,8'h00,1,0,8'h00,0,0), T(1,c,0,w));
      stepchk($sformatf("drain_gap[%0d]", k), I(0,0,8'h00,1,0,8'h00,0,0),
              T(1,c,(k < 3),8'h00));
    end
    stepchk("drained", I(0,0,8'h00,1,0,8'h00,0,0), T(1,0,0,8'h00));
    // Pointer wrap
    stepchk("wrap_p0", I(0,1,8'h10,0,0,8'h00,0,0), T(1,1,0,8'h00));
    stepchk("wrap_p1", I(0,1,8'h11,0,0,8'h00,0,0), T(1,2,1,8'h00));
    stepchk("wrap_d0", I(0,0,8'h00,1,0,8'h00,0,0), T(1,1,0,8'h10));
    stepchk("wrap_g0", NOP,                        T(1,1,1,8'h00));
    stepchk("wrap_d1", I(0,0,8'h00,1,0,8'h00,0,0), T(1,0,0,8'h11));
    stepchk("wrap_g1", NOP,                        T(1,0,0,8'h00));

    // Simultaneous grant and push while full: push rejected
    stepchk("full_p0", I(0,1,8'h20,0,0,8'h00,0,0), T(1,1,0,8'h00));
    stepchk("full_p1", I(0,1,8'h21,0,0,8'h00,0,0), T(1,2,1,8'h00));
    stepchk("full_p2", I(0,1,8'h22,0,0,8'h00,0,0), T(1,3,1,8'h00));
    stepchk("full_p3", I(0,1,8'h23,0,0,8'h00,0,0), T(0,4,1,8'h00));
    stepchk("full_pp", I(0,1,8'h24,1,0,8'h00,0,0), T(1,3,0,8'h20));
    for (int k = 0; k < 3; k++) begin
      logic [DW-1:0] w;
      w = DW'(8'h21 + k);
      stepchk($sformatf("full_g[%0d]", k), NOP, T(1,3'(3 - k),1,8'h00));
      stepchk($sformatf("full_d[%0d]", k), I(0,0,8'h00,1,0,8'h00,0,0), T(1,3'(2 - k),0,w));
    end
    stepchk("full_end", NOP, T(1,0,0,8'h00));

    // Reset during DRIVE with two words still queued
    stepchk("mid_p0", I(0,1,8'h30,0,0,8'h00,0,0), T(1,1,0,8'h00));
    stepchk("mid_p1", I(0,1,8'h31,0,0,8'h00,0,0), T(1,2,1,8'h00));
    stepchk("mid_p2", I(0,1,8'h32,0,0,8'h00,0,0), T(1,3,1,8'h00));
    stepchk("mid_drv", I(0,0,8'h00,1,0,8'h00,0,0), T(1,2,0,8'h30));
    stepchk("mid_rst", I(1,0,8'h00,0,0,8'h00,0,0), T(1,0,0,8'h00));
    for (int k = 0; k < 4; k++)
      stepchk($sformatf("mid_after[%0d]", k), I(0,0,8'h00,1,0,8'h00,0,0), T(1,0,0,8'h00));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
